// File: rtl/usb2_mon_pkg.sv
// Shared constants for the USB2 PHY clock-ready monitor.
// Holds the FSM state encodings, the default monitor parameters and the derived edge-count width.
package usb2_mon_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_QUALIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  localparam int unsigned DEF_WINDOW_BITS  = 12;
  localparam int unsigned DEF_CNT_MIN      = 2400;
  localparam int unsigned DEF_CNT_MAX      = 2515;
  localparam int unsigned DEF_GOOD_WINDOWS = 4;

  // Edge counter is one bit wider than the window counter.
  localparam int unsigned DEF_CNT_W = DEF_WINDOW_BITS + 1;

endpackage

// File: rtl/cdc_sync_bit.sv
// Single-bit multi-flop synchronizer.
// Ports:
//   i_clk   - destination clock
//   i_rst_n - asynchronous active-low reset
//   i_d     - asynchronous input bit
//   o_q     - synchronized output (N_STAGES cycles of latency)
// N_STAGES must be at least 2.
module cdc_sync_bit #(
  parameter int unsigned N_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [N_STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[N_STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[N_STAGES-1];

endmodule

// File: rtl/usb2_clk_ready_mon.sv
// USB2 ULPI PHY clock frequency monitor, entirely in the cfg_mclk domain.
// Counts toggle edges from the PHY domain over 2^WINDOW_BITS-cycle windows, checks each count
// against [CNT_MIN, CNT_MAX] and raises ready after GOOD_WINDOWS consecutive in-band windows.
// Ports:
//   i_cfg_mclk         - the only clock
//   i_cfg_mrst_n       - asynchronous active-low reset
//   i_mon_en           - monitoring enable (level); low forces IDLE
//   i_phy_clk_tgl      - asynchronous toggle, inverts on every PHY clock rising edge
//   o_usb2_clk_ready   - PHY clock present and in band
//   o_clk_lost         - one-cycle pulse when ready drops due to a bad window
//   o_cnt_valid        - one-cycle pulse when o_cnt_last updates
//   o_cnt_last         - edge count of the most recently completed window
//   o_debug_state      - current FSM state encoding
module usb2_clk_ready_mon
  import usb2_mon_pkg::*;
#(
  parameter int unsigned WINDOW_BITS  = DEF_WINDOW_BITS,
  parameter int unsigned CNT_MIN      = DEF_CNT_MIN,
  parameter int unsigned CNT_MAX      = DEF_CNT_MAX,
  parameter int unsigned GOOD_WINDOWS = DEF_GOOD_WINDOWS
) (
  input  logic                 i_cfg_mclk,
  input  logic                 i_cfg_mrst_n,
  input  logic                 i_mon_en,
  input  logic                 i_phy_clk_tgl,
  output logic                 o_usb2_clk_ready,
  output logic                 o_clk_lost,
  output logic                 o_cnt_valid,
  output logic [WINDOW_BITS:0] o_cnt_last,
  output logic [1:0]           o_debug_state
);

  localparam int unsigned CW = WINDOW_BITS + 1;
  localparam logic [CW-1:0] LP_CNT_MIN = CW'(CNT_MIN);
  localparam logic [CW-1:0] LP_CNT_MAX = CW'(CNT_MAX);
  localparam logic [3:0]    LP_GOOD    = 4'(GOOD_WINDOWS);

  logic                   w_tgl_sync;
  logic                   r_tgl_hist;
  logic                   w_edge;
  logic [WINDOW_BITS-1:0] r_win_cnt, w_win_cnt_d;
  logic [CW-1:0]          r_edge_cnt, w_edge_cnt_d, w_edge_sum;
  logic [3:0]             r_good_cnt, w_good_cnt_d, w_good_inc;
  logic [1:0]             r_state, w_state_d;
  logic                   r_ready, w_ready_d;
  logic                   r_clk_lost, w_clk_lost_d;
  logic                   r_cnt_valid, w_cnt_valid_d;
  logic [CW-1:0]          r_cnt_last, w_cnt_last_d;
  logic                   w_terminal;
  logic                   w_in_band;

  cdc_sync_bit #(
    .N_STAGES (2)
  ) u_tgl_sync (
    .i_clk   (i_cfg_mclk),
    .i_rst_n (i_cfg_mrst_n),
    .i_d     (i_phy_clk_tgl),
    .o_q     (w_tgl_sync)
  );

  // Any change of the synchronized toggle is one PHY clock cycle.
  assign w_edge     = w_tgl_sync ^ r_tgl_hist;
  assign w_edge_sum = (&r_edge_cnt) ? r_edge_cnt : r_edge_cnt + CW'(w_edge);
  assign w_terminal = &r_win_cnt;
  assign w_in_band  = (w_edge_sum >= LP_CNT_MIN) && (w_edge_sum <= LP_CNT_MAX);
  assign w_good_inc = r_good_cnt + 4'd1;

  always_comb begin
    w_state_d     = r_state;
    w_win_cnt_d   = r_win_cnt;
    w_edge_cnt_d  = r_edge_cnt;
    w_good_cnt_d  = r_good_cnt;
    w_ready_d     = r_ready;
    w_clk_lost_d  = 1'b0;
    w_cnt_valid_d = 1'b0;
    w_cnt_last_d  = r_cnt_last;

    // Disable wins over everything, including a terminal window; cnt_last is kept.
    if (!i_mon_en) begin
      w_state_d    = ST_IDLE;
      w_win_cnt_d  = '0;
      w_edge_cnt_d = '0;
      w_good_cnt_d = '0;
      w_ready_d    = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_d    = ST_QUALIFY;
          w_win_cnt_d  = '0;
          w_edge_cnt_d = '0;
          w_good_cnt_d = '0;
          w_ready_d    = 1'b0;
        end
        ST_QUALIFY, ST_LOCKED: begin
          w_win_cnt_d  = r_win_cnt + WINDOW_BITS'(1);
          w_edge_cnt_d = w_edge_sum;
          if (w_terminal) begin
            w_edge_cnt_d  = '0;
            w_cnt_last_d  = w_edge_sum;
            w_cnt_valid_d = 1'b1;
            if (r_state == ST_QUALIFY) begin
              if (w_in_band) begin
                w_good_cnt_d = w_good_inc;
                if (w_good_inc >= LP_GOOD) begin
                  w_state_d = ST_LOCKED;
                  w_ready_d = 1'b1;
                end
              end else begin
                w_good_cnt_d = '0;
              end
            end else if (!w_in_band) begin
              w_state_d    = ST_QUALIFY;
              w_ready_d    = 1'b0;
              w_clk_lost_d = 1'b1;
              w_good_cnt_d = '0;
            end
          end
        end
        default: begin
          // Illegal encoding recovers to IDLE.
          w_state_d    = ST_IDLE;
          w_win_cnt_d  = '0;
          w_edge_cnt_d = '0;
          w_good_cnt_d = '0;
          w_ready_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge i_cfg_mclk or negedge i_cfg_mrst_n) begin
    if (!i_cfg_mrst_n) begin
      r_tgl_hist  <= 1'b0;
      r_state     <= ST_IDLE;
      r_win_cnt   <= '0;
      r_edge_cnt  <= '0;
      r_good_cnt  <= '0;
      r_ready     <= 1'b0;
      r_clk_lost  <= 1'b0;
      r_cnt_valid <= 1'b0;
      r_cnt_last  <= '0;
    end else begin
      r_tgl_hist  <= w_tgl_sync;
      r_state     <= w_state_d;
      r_win_cnt   <= w_win_cnt_d;
      r_edge_cnt  <= w_edge_cnt_d;
      r_good_cnt  <= w_good_cnt_d;
      r_ready     <= w_ready_d;
      r_clk_lost  <= w_clk_lost_d;
      r_cnt_valid <= w_cnt_valid_d;
      r_cnt_last  <= w_cnt_last_d;
    end
  end

  assign o_usb2_clk_ready = r_ready;
  assign o_clk_lost       = r_clk_lost;
  assign o_cnt_valid      = r_cnt_valid;
  assign o_cnt_last       = r_cnt_last;
  assign o_debug_state    = r_state;

endmodule
